// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and 8N1 frame constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4,
    BREAK   = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the async RX line, plus an optional 2-of-3 majority filter.
// Latency: o_Sync lags i_Rx_Serial by two clock edges; o_Sample is combinational on top.
// Backpressure: none, free-running.
//
// Ports: i_Clock, i_Rst_n (async active-low), i_Rx_Serial (raw line),
//        o_Sync (synchronised line s), o_Sample (decision sample).
// Macro UART_RX_MAJORITY_EN: when defined, o_Sample is the majority of s over
// the current and two preceding edges; otherwise o_Sample is s.
module uart_rx_sync (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic i_Rx_Serial,
  output logic o_Sync,
  output logic o_Sample
);

  logic [1:0] sync_q;

  // Line idles high, so reset to 1 keeps the receiver from seeing a false start.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], i_Rx_Serial};
    end
  end

  assign o_Sync = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  // hist shifts in the first-stage flop, so hist[0] always equals s and
  // hist[2:1] hold s from the two previous edges.
  logic [2:0] hist_q;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      hist_q <= 3'b111;
    end else begin
      hist_q <= {hist_q[1:0], sync_q[0]};
    end
  end

  assign o_Sample = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
`else
  assign o_Sample = sync_q[1];
`endif

endmodule

// File: rtl/uart_test_rx.sv
// 8N1 UART receiver: one-cycle DV pulse per good byte, one-cycle pulse per bad stop bit.
// Latency: result pulses on the cycle after the stop-bit sample edge (start detect + h + 9 bit periods).
// Backpressure: none; the consumer must take o_Rx_Byte before the next o_Rx_DV pulse.
//
// Ports: i_Clock, i_Rst_n (async active-low), i_Rx_Serial (line, idles high),
//        o_Rx_DV, o_Rx_Byte[7:0], o_Rx_Frame_Err, o_Rx_Active.
// Parameter CLKS_PER_BIT (4..65535). Optional macro UART_RX_MAJORITY_EN
// enables majority-filtered decision samples in uart_rx_sync.
module uart_test_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Active
);

  localparam logic [15:0] HALF_CNT = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_IDX = 3'(DATA_BITS - 1);

  logic s;
  logic sample;

  uart_rx_sync u_sync (
    .i_Clock     (i_Clock),
    .i_Rst_n     (i_Rst_n),
    .i_Rx_Serial (i_Rx_Serial),
    .o_Sync      (s),
    .o_Sample    (sample)
  );

  rx_state_t   state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [7:0]  shift_q, shift_nxt;
  logic [7:0]  byte_nxt;
  logic        dv_nxt, ferr_nxt, active_nxt;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      idx            <= '0;
      shift_q        <= '0;
      o_Rx_Byte      <= '0;
      o_Rx_DV        <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
      o_Rx_Active    <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      idx            <= idx_nxt;
      shift_q        <= shift_nxt;
      o_Rx_Byte      <= byte_nxt;
      o_Rx_DV        <= dv_nxt;
      o_Rx_Frame_Err <= ferr_nxt;
      o_Rx_Active    <= active_nxt;
    end
  end

  // Pulses default low, so every non-STOP cycle clears them.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    idx_nxt    = idx;
    shift_nxt  = shift_q;
    byte_nxt   = o_Rx_Byte;
    dv_nxt     = 1'b0;
    ferr_nxt   = 1'b0;
    active_nxt = o_Rx_Active;

    case (state)
      IDLE: begin
        cnt_nxt    = '0;
        idx_nxt    = '0;
        active_nxt = 1'b0;
        if (!s) begin
          state_nxt  = START;
          active_nxt = 1'b1;
        end
      end

      START: begin
        if (cnt == HALF_CNT) begin
          cnt_nxt = '0;
          if (!sample) begin
            state_nxt = DATA;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_nxt  = IDLE;
            active_nxt = 1'b0;
          end
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end

      DATA: begin
        if (cnt == LAST_CNT) begin
          cnt_nxt            = '0;
          shift_nxt[idx]     = sample;
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = STOP;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end

      STOP: begin
        if (cnt == LAST_CNT) begin
          cnt_nxt    = '0;
          active_nxt = 1'b0;
          if (sample) begin
            byte_nxt  = shift_q;
            dv_nxt    = 1'b1;
            state_nxt = CLEANUP;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = BREAK;
          end
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end

      CLEANUP: state_nxt = IDLE;

      // Wait for the line to recover so a held-low line is not re-read as starts.
      BREAK: begin
        if (s) begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
